// File: rtl/decoder_pipe_pkg.sv
// Shared widths and the one-hot helper for the decoder pipe and other one-hot select paths.
package decoder_pkg;
   localparam int CODE_W    = 3;
   localparam int DATA_W    = 8;
   localparam int BUF_DEPTH = 2;
   localparam int PTR_W     = $clog2(BUF_DEPTH);
   localparam int CNT_W     = $clog2(BUF_DEPTH + 1);

   function automatic logic [DATA_W-1:0] onehot_of(input logic [CODE_W-1:0] code);
      return DATA_W'(1) << code;
   endfunction
endpackage

// File: rtl/decoder_pipe_if.sv
// Code-in / one-hot-out bus of the decoder pipe; slave is the decoder side, master the environment.
// Handshake: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
interface decoder_pipe_if #(
   parameter int CODE_W = decoder_pkg::CODE_W,
   parameter int DATA_W = decoder_pkg::DATA_W
);
   logic [CODE_W-1:0]            Code;
   logic                         code_valid;
   logic                         code_ready;
   logic [DATA_W-1:0]            Data;
   logic                         data_valid;
   logic                         data_ready;
   logic [decoder_pkg::CNT_W-1:0] count;

   modport master (
      output Code, code_valid, data_ready,
      input  code_ready, Data, data_valid, count
   );

   modport slave (
      input  Code, code_valid, data_ready,
      output code_ready, Data, data_valid, count
   );
endinterface

// File: rtl/decoder_pipe_onehot_buf.sv
// Two-entry FIFO for one-hot select words; empty head reads as zero so consumers never see X.
module onehot_buf
   import decoder_pkg::*;
#(
   parameter int W = DATA_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [W-1:0]     wdata,
   input  logic             pop,
   output logic [W-1:0]     rdata,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);
   logic [W-1:0]     mem_q [BUF_DEPTH];
   logic [W-1:0]     mem_d [BUF_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == CNT_W'(BUF_DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign count   = count_q;
   assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      // Push and pop together leave occupancy unchanged.
      if (do_push && !do_pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (do_pop && !do_push) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < BUF_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end
endmodule

// File: rtl/decoder_pipe.sv
// Registered 3-to-8 one-hot decoder with a two-word output buffer absorbing consumer back-pressure.
module decoder_pipe
   import decoder_pkg::*;
(
   input logic           clock,
   input logic           reset,
   decoder_pipe_if.slave bus
);
   logic              push, pop;
   logic              full, empty;
   logic [DATA_W-1:0] head;
   logic [CNT_W-1:0]  occ;

   // code_ready depends only on occupancy, so a full buffer refuses a push even while popping.
   assign bus.code_ready = !full;
   assign bus.data_valid = !empty;
   assign bus.Data       = head;
   assign bus.count      = occ;
   assign push           = bus.code_valid && !full;
   assign pop            = bus.data_ready && !empty;

   onehot_buf #(.W(DATA_W)) u_buf (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .wdata (onehot_of(bus.Code)),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (occ)
   );
endmodule
